signed_add_rr_scheduler: RTL and testbench

- Shares one W-bit two's-complement adder with overflow detection among N_REQ requesters.
- Round-robin arbitration. Each requester gets a valid/ready handshake.
- One result register, with a valid/ready handshake to the consumer. Each result is tagged with the requester ID.
- Sits between multiple arithmetic producers and one shared adder instance in the arithmetic/pipelining section.

---
 rtl/signed_add_rr_scheduler_pkg.sv | 29 ++
 rtl/signed_add_rr_scheduler_if.sv | 29 ++
 rtl/signed_add_rr_scheduler_arbiter.sv | 32 +++
 rtl/signed_add_rr_scheduler.sv | 128 ++++++++++++
 tb/tb_signed_add_rr_scheduler.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/signed_add_rr_scheduler_pkg.sv
// Shared types and arithmetic helpers for the signed-add round-robin scheduler.
// The helpers work on a wide container so any operand width up to MaxW can reuse them.
package signed_add_sched_pkg;

  localparam int unsigned DefW    = 4;
  localparam int unsigned DefNReq = 4;
  localparam int unsigned MaxW    = 64;

  typedef logic signed [DefW-1:0] operand_t;
  typedef logic [MaxW-1:0]        wide_t;

  // Returns {overflow, sum}. Only the low w bits of sum are meaningful; overflow is
  // judged on bit w-1 of the unsaturated sum.
  function automatic logic [MaxW:0] add_ovf(wide_t a, wide_t b, int unsigned w);
    wide_t s;
    logic  ov;
    s  = a + b;
    ov = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, s};
  endfunction

  // Signed extreme for a w-bit result: most negative when neg, else most positive.
  function automatic wide_t sat_limit(logic neg, int unsigned w);
    wide_t lim;
    lim = wide_t'(1) << (w - 1);
    return neg ? lim : (lim - wide_t'(1));
  endfunction

endpackage

// File: rtl/signed_add_rr_scheduler_if.sv
// Requester, result and sticky-status signals of the signed-add scheduler.
// master: producers/consumer side; slave: the scheduler.
interface signed_add_rr_scheduler_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               res_valid;
  logic               res_ready;
  logic [W-1:0]       res_sum;
  logic               res_overflow;
  logic [ID_W-1:0]    res_id;
  logic [N_REQ-1:0]   ovf_sticky;
  logic [N_REQ-1:0]   ovf_clr;

  modport master (
    output req_valid, req_a, req_b, res_ready, ovf_clr,
    input  req_ready, res_valid, res_sum, res_overflow, res_id, ovf_sticky
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready, ovf_clr,
    output req_ready, res_valid, res_sum, res_overflow, res_id, ovf_sticky
  );
endinterface

// File: rtl/signed_add_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: searches valid_i from ptr_i upward, wrapping.
// gnt_o is one-hot (gated by en_i); idx_o/any_o report the winner regardless of en_i.
module rr_arbiter_n #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // First valid index at or after the pointer, modulo N.
  always_comb begin
    int unsigned j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && valid_i[j]) begin
        any_o    = 1'b1;
        idx_o    = IDX_W'(j);
        gnt_o[j] = en_i;
      end
    end
  end

endmodule

// File: rtl/signed_add_rr_scheduler.sv
// Shares one W-bit signed adder among N_REQ requesters with round-robin arbitration and a
// single tagged result register. Define SIGNED_ADD_SATURATE_EN to clamp overflowed sums to
// the signed extreme instead of wrapping.
module signed_add_rr_scheduler
  import signed_add_sched_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned N_REQ = DefNReq,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  signed_add_rr_scheduler_if.slave    bus_io
);

  logic             res_valid_q, res_valid_d;
  logic [W-1:0]     res_sum_q, res_sum_d;
  logic             res_ovf_q, res_ovf_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] sticky_q, sticky_d;

  logic             can_issue;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic             xfer;
  logic [W-1:0]     a_sel, b_sel;
  logic [MaxW:0]    add_res;
  wide_t            sum_full;
  logic             ovf;
  logic             unused_sum_hi;

  // Output register empty or draining this cycle.
  assign can_issue = ~res_valid_q | bus_io.res_ready;

  rr_arbiter_n #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .valid_i (bus_io.req_valid),
    .ptr_i   (ptr_q),
    .en_i    (can_issue),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  assign bus_io.req_ready = gnt;
  assign xfer             = gnt_any & can_issue;

  // Operand mux for the winning requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        a_sel = bus_io.req_a[i*W +: W];
        b_sel = bus_io.req_b[i*W +: W];
      end
    end
  end

  // Shared adder with overflow detect, optional clamp.
  always_comb begin
    wide_t a_w, b_w;
    a_w          = '0;
    b_w          = '0;
    a_w[W-1:0]   = a_sel;
    b_w[W-1:0]   = b_sel;
    add_res      = add_ovf(a_w, b_w, W);
    ovf          = add_res[MaxW];
`ifdef SIGNED_ADD_SATURATE_EN
    sum_full     = ovf ? sat_limit(a_sel[W-1], W) : add_res[MaxW-1:0];
`else
    sum_full     = add_res[MaxW-1:0];
`endif
  end

  assign unused_sum_hi = ^sum_full[MaxW-1:W];

  // Next-state: result register, round-robin pointer and sticky overflow bits.
  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_ovf_d   = res_ovf_q;
    res_id_d    = res_id_q;
    ptr_d       = ptr_q;
    sticky_d    = sticky_q & ~bus_io.ovf_clr;
    if (xfer) begin
      res_valid_d = 1'b1;
      res_sum_d   = sum_full[W-1:0];
      res_ovf_d   = ovf;
      res_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : ID_W'(gnt_idx + 1'b1);
      // Set after clear so a same-cycle set wins.
      if (ovf) sticky_d[gnt_idx] = 1'b1;
    end else if (bus_io.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= '0;
      ptr_q       <= '0;
      sticky_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_ovf_q   <= res_ovf_d;
      res_id_q    <= res_id_d;
      ptr_q       <= ptr_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus_io.res_valid    = res_valid_q;
  assign bus_io.res_sum      = res_sum_q;
  assign bus_io.res_overflow = res_ovf_q;
  assign bus_io.res_id       = res_id_q;
  assign bus_io.ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_signed_add_rr_scheduler.sv
// Directed bench for signed_add_rr_scheduler (W=4, N_REQ=4); honours SIGNED_ADD_SATURATE_EN.
module tb_signed_add_rr_scheduler;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

`ifdef SIGNED_ADD_SATURATE_EN
  localparam logic [3:0] PosOvfSum = 4'b0111;
  localparam logic [3:0] NegOvfSum = 4'b1000;
  localparam logic [3:0] SevSevSum = 4'b0111;
`else
  localparam logic [3:0] PosOvfSum = 4'b1000;
  localparam logic [3:0] NegOvfSum = 4'b0111;
  localparam logic [3:0] SevSevSum = 4'b1110;
`endif

  signed_add_rr_scheduler_if #(.W(4), .N_REQ(4)) bus ();

  signed_add_rr_scheduler #(.W(4), .N_REQ(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.req_a[i*4 +: 4] = a;
    bus.req_b[i*4 +: 4] = b;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [3:0] s,
                         input logic o, input logic [1:0] id);
    chk({tag, ".valid"}, 32'(bus.res_valid), 32'(v));
    chk({tag, ".sum"}, 32'(bus.res_sum), 32'(s));
    chk({tag, ".ovf"}, 32'(bus.res_overflow), 32'(o));
    chk({tag, ".id"}, 32'(bus.res_id), 32'(id));
  endtask

  initial begin
    n_vec         = 0;
    n_miss        = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
    bus.ovf_clr   = '0;

    // Reset state
    step();
    step();
    chk_res("reset", 1'b0, 4'd0, 1'b0, 2'd0);
    chk("reset.sticky", 32'(bus.ovf_sticky), 32'h0);
    chk("reset.ready", 32'(bus.req_ready), 32'h0);
    rst_n = 1'b1;
    step();

    // Single requester 1: 3+2
    set_op(1, 4'd3, 4'd2);
    bus.req_valid = 4'b0010;
    bus.res_ready = 1'b1;
    #1 chk("single.ready", 32'(bus.req_ready), 32'b0010);
    step();
    chk_res("single", 1'b1, 4'd5, 1'b0, 2'd1);
    bus.req_valid = '0;
    step();
    chk("drain.valid", 32'(bus.res_valid), 32'h0);

    // Pointer now 2: with 0,1,2 valid, 2 wins. Dropped before the edge (no transfer).
    bus.req_valid = 4'b0111;
    #1 chk("ptr2.ready", 32'(bus.req_ready), 32'b0100);
    bus.req_valid = '0;

    // Positive overflow on requester 0: 7+1
    set_op(0, 4'd7, 4'd1);
    bus.req_valid = 4'b0001;
    #1 chk("posovf.ready", 32'(bus.req_ready), 32'b0001);
    step();
    chk_res("posovf", 1'b1, PosOvfSum, 1'b1, 2'd0);
    chk("posovf.sticky", 32'(bus.ovf_sticky), 32'b0001);

    // Negative overflow on requester 3: -8 + -1, back-to-back with the drain
    set_op(3, 4'b1000, 4'b1111);
    bus.req_valid = 4'b1000;
    #1 chk("negovf.ready", 32'(bus.req_ready), 32'b1000);
    step();
    chk_res("negovf", 1'b1, NegOvfSum, 1'b1, 2'd3);
    chk("negovf.sticky", 32'(bus.ovf_sticky), 32'b1001);

    // All requesters valid: pointer wrapped to 0, grants 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_op(i, 4'(i), 4'd1);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("rr%0d.ready", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
      step();
      chk_res($sformatf("rr%0d", k), 1'b1, 4'((k % 4) + 1), 1'b0, 2'(k % 4));
    end
    chk("rr.sticky", 32'(bus.ovf_sticky), 32'b1001);

    // Backpressure: result id0/sum1 held for 3 cycles, no grants
    bus.res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d.ready", k), 32'(bus.req_ready), 32'h0);
      step();
      chk_res($sformatf("bp%0d", k), 1'b1, 4'd1, 1'b0, 2'd0);
    end
    bus.res_ready = 1'b1;
    #1 chk("bprel.ready", 32'(bus.req_ready), 32'b0010);
    step();
    chk_res("bprel", 1'b1, 4'd2, 1'b0, 2'd1);

    // Clear and set of sticky bit 0 in the same cycle: set wins
    set_op(0, 4'd7, 4'd1);
    bus.req_valid = 4'b0001;
    bus.ovf_clr   = 4'b0001;
    #1 chk("clrset.ready", 32'(bus.req_ready), 32'b0001);
    step();
    chk_res("clrset", 1'b1, PosOvfSum, 1'b1, 2'd0);
    chk("clrset.sticky", 32'(bus.ovf_sticky), 32'b1001);
    bus.req_valid = '0;
    step();
    chk("clr.sticky", 32'(bus.ovf_sticky), 32'b1000);
    chk("clr.valid", 32'(bus.res_valid), 32'h0);
    bus.ovf_clr = '0;

    // Overflow on requester 1 (7+7), then reset mid-stream
    set_op(1, 4'd7, 4'd7);
    bus.req_valid = 4'b0010;
    #1 chk("pre_rst.ready", 32'(bus.req_ready), 32'b0010);
    step();
    chk_res("pre_rst", 1'b1, SevSevSum, 1'b1, 2'd1);
    chk("pre_rst.sticky", 32'(bus.ovf_sticky), 32'b1010);
    bus.req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_res("midrst", 1'b0, 4'd0, 1'b0, 2'd0);
    chk("midrst.sticky", 32'(bus.ovf_sticky), 32'h0);
    chk("midrst.ready", 32'(bus.req_ready), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
